// File: rtl/sseg_scan_decoder_if.sv
// sseg_scan_decoder_if
//    Bundles the sniffed seven-segment scan lines and the decoded results.
//    master : drives segs/digit_sel (the display driver side), reads results.
//    slave  : the decoder; reads segs/digit_sel, drives results.
//    segs        7 bits, active-low {g,f,e,d,c,b,a}
//    digit_sel   NUM_DIGITS bits, active-high digit enable
//    value       4 bits per digit, digit i in [4i+3:4i]
//    neg/blank/invalid  per-digit classification flags
//    frame_valid one-cycle pulse after every digit has been captured
//    sel_err     sticky flag for a stable non-one-hot digit_sel
interface sseg_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              segs;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   neg;
   logic [NUM_DIGITS-1:0]   blank;
   logic [NUM_DIGITS-1:0]   invalid;
   logic                    frame_valid;
   logic                    sel_err;

   modport master (
      output segs, digit_sel,
      input  value, neg, blank, invalid, frame_valid, sel_err
   );

   modport slave (
      input  segs, digit_sel,
      output value, neg, blank, invalid, frame_valid, sel_err
   );
endinterface

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder
//    Observes a multiplexed seven-segment display bus and recovers the value
//    shown on each digit. A sample {digit_sel, segs} must be seen on
//    STABLE_CYCLES consecutive edges before it is captured into the slot
//    selected by a one-hot digit_sel.
//    clk   : system clock, rising edge
//    rst_n : synchronous active-low reset
//    bus   : sseg_scan_decoder_if.slave (scan inputs, decoded outputs)
module sseg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sseg_scan_decoder_if.slave   bus
);

   localparam int SW = NUM_DIGITS + 7;
   // cnt_r holds "edges in the current run minus one"; the run reaches
   // STABLE_CYCLES samples on the edge where cnt_r already equals CNT_CAP.
   localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);
   localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES - 1);

   // Returns {invalid, blank, neg, nibble} for an active-low segment pattern.
   function automatic logic [6:0] decode(input logic [6:0] s);
      logic [6:0] r;
      case (s)
         7'b1000000: r = {3'b000, 4'h0};
         7'b1111001: r = {3'b000, 4'h1};
         7'b0100100: r = {3'b000, 4'h2};
         7'b0110000: r = {3'b000, 4'h3};
         7'b0011001: r = {3'b000, 4'h4};
         7'b0010010: r = {3'b000, 4'h5};
         7'b0000010: r = {3'b000, 4'h6};
         7'b1111000: r = {3'b000, 4'h7};
         7'b0000000: r = {3'b000, 4'h8};
         7'b0011000: r = {3'b000, 4'h9};
         7'b0001000: r = {3'b000, 4'hA};
         7'b0000011: r = {3'b000, 4'hB};
         7'b1000110: r = {3'b000, 4'hC};
         7'b0100001: r = {3'b000, 4'hD};
         7'b0000110: r = {3'b000, 4'hE};
         7'b0001110: r = {3'b000, 4'hF};
         7'b0111111: r = {3'b001, 4'h0};
         7'b1111111: r = {3'b010, 4'h0};
         default:    r = {3'b100, 4'h0};
      endcase
      return r;
   endfunction

   function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] s);
      return (s != '0) && ((s & (s - NUM_DIGITS'(1))) == '0);
   endfunction

   logic [SW-1:0]           samp_r;
   logic                    samp_ok_r;   // low until a post-reset sample exists
   logic [7:0]              cnt_r;
   logic [4*NUM_DIGITS-1:0] value_r;
   logic [NUM_DIGITS-1:0]   neg_r;
   logic [NUM_DIGITS-1:0]   blank_r;
   logic [NUM_DIGITS-1:0]   invalid_r;
   logic [NUM_DIGITS-1:0]   seen_r;
   logic                    fv_r;
   logic                    sel_err_r;

   logic [SW-1:0]           samp_in_s;
   logic                    same_s;
   logic                    cap_s;
   logic                    sel_ok_s;
   logic                    full_s;
   logic [NUM_DIGITS-1:0]   cap_bits_s;
   logic [6:0]              dec_s;

   // Run detection and capture qualification.
   always_comb begin
      samp_in_s  = {bus.digit_sel, bus.segs};
      same_s     = samp_ok_r && (samp_in_s == samp_r);
      cap_s      = same_s && (cnt_r == CNT_CAP);
      sel_ok_s   = is_onehot(samp_r[SW-1:7]);
      full_s     = &seen_r;
      dec_s      = decode(samp_r[6:0]);
      if (cap_s && sel_ok_s) begin
         cap_bits_s = samp_r[SW-1:7];
      end else begin
         cap_bits_s = '0;
      end
   end

   // Sample register and saturating stability counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         samp_r    <= '0;
         samp_ok_r <= 1'b0;
         cnt_r     <= 8'd0;
      end else begin
         samp_r    <= samp_in_s;
         samp_ok_r <= 1'b1;
         if (!same_s) begin
            cnt_r <= 8'd0;
         end else if (cnt_r != CNT_SAT) begin
            cnt_r <= cnt_r + 8'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Per-digit result slots, written only by a one-hot capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_r   <= '0;
         neg_r     <= '0;
         blank_r   <= '1;
         invalid_r <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_bits_s[i]) begin
               value_r[4*i +: 4] <= dec_s[3:0];
               neg_r[i]          <= dec_s[4];
               blank_r[i]        <= dec_s[5];
               invalid_r[i]      <= dec_s[6];
            end
         end
      end
   end

   // Frame tracking: a full seen mask pulses frame_valid and restarts the
   // mask; a capture on that same edge lands in the fresh mask.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen_r    <= '0;
         fv_r      <= 1'b0;
         sel_err_r <= 1'b0;
      end else begin
         fv_r   <= full_s;
         seen_r <= (full_s ? '0 : seen_r) | cap_bits_s;
         if (cap_s && !sel_ok_s) begin
            sel_err_r <= 1'b1;
         end
      end
   end

   assign bus.value       = value_r;
   assign bus.neg         = neg_r;
   assign bus.blank       = blank_r;
   assign bus.invalid     = invalid_r;
   assign bus.frame_valid = fv_r;
   assign bus.sel_err     = sel_err_r;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb_sseg_scan_decoder
//    Directed bench for sseg_scan_decoder: a 4-digit instance plus a
//    1-digit instance sharing clock and reset.
module tb_sseg_scan_decoder;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   sseg_scan_decoder_if #(.NUM_DIGITS(4)) bus  ();
   sseg_scan_decoder_if #(.NUM_DIGITS(1)) bus1 ();

   sseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sseg_scan_decoder #(.NUM_DIGITS(1), .STABLE_CYCLES(4)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input logic [3:0] sel, input logic [6:0] sg);
      bus.digit_sel = sel;
      bus.segs      = sg;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      show(4'b0000, 7'b1111111);
      bus1.digit_sel = 1'b1;
      bus1.segs      = 7'b0011000;
      step(2);
      chk("rst_value",   32'(bus.value),       32'h0000);
      chk("rst_neg",     32'(bus.neg),         32'h0);
      chk("rst_blank",   32'(bus.blank),       32'hF);
      chk("rst_invalid", 32'(bus.invalid),     32'h0);
      chk("rst_fv",      32'(bus.frame_valid), 32'h0);
      chk("rst_selerr",  32'(bus.sel_err),     32'h0);

      // Digit 0 shows "2" for 4 edges.
      rst_n = 1'b1;
      show(4'b0001, 7'b0100100);
      step(3);
      chk("d0_early",    32'(bus.value), 32'h0000);
      step(1);
      chk("d0_value",    32'(bus.value), 32'h0002);
      chk("d0_blank",    32'(bus.blank), 32'hE);
      chk("d0_fv",       32'(bus.frame_valid), 32'h0);
      chk("n1_value",    32'(bus1.value), 32'h9);
      chk("n1_fv_early", 32'(bus1.frame_valid), 32'h0);

      // Digit 1: "4" only 3 edges, then "3" for 4 edges.
      show(4'b0010, 7'b0011001);
      step(1);
      chk("n1_fv",       32'(bus1.frame_valid), 32'h1);
      step(2);
      show(4'b0010, 7'b0110000);
      step(3);
      chk("d1_nocap",    32'(bus.value), 32'h0002);
      step(1);
      chk("d1_value",    32'(bus.value), 32'h0032);
      chk("d1_blank",    32'(bus.blank), 32'hC);
      chk("n1_fv_once",  32'(bus1.frame_valid), 32'h0);

      // Full scan with minus, blank, invalid and F.
      show(4'b0001, 7'b0111111); step(5);
      show(4'b0010, 7'b1111111); step(5);
      show(4'b0100, 7'b1010101); step(5);
      show(4'b1000, 7'b0001110); step(4);
      chk("scan_value",   32'(bus.value),   32'hF000);
      chk("scan_neg",     32'(bus.neg),     32'h1);
      chk("scan_blank",   32'(bus.blank),   32'h2);
      chk("scan_invalid", 32'(bus.invalid), 32'h4);
      chk("scan_fv_pre",  32'(bus.frame_valid), 32'h0);
      step(1);
      chk("scan_fv",      32'(bus.frame_valid), 32'h1);

      // Multi-hot select held stable.
      show(4'b0110, 7'b1000000);
      step(1);
      chk("scan_fv_drop", 32'(bus.frame_valid), 32'h0);
      step(3);
      chk("mh_selerr",    32'(bus.sel_err), 32'h1);
      chk("mh_value",     32'(bus.value),   32'hF000);
      chk("mh_neg",       32'(bus.neg),     32'h1);
      step(5);
      chk("mh_sticky",    32'(bus.sel_err), 32'h1);

      // Valid scan after the error still completes a frame.
      show(4'b0001, 7'b1111001); step(4);
      show(4'b0010, 7'b1111000); step(4);
      show(4'b0100, 7'b0000000); step(4);
      show(4'b1000, 7'b1000110); step(4);
      chk("s2_value",   32'(bus.value),   32'hC871);
      chk("s2_flags",   32'({bus.neg, bus.blank, bus.invalid}), 32'h000);
      chk("s2_fv_pre",  32'(bus.frame_valid), 32'h0);
      step(1);
      chk("s2_fv",      32'(bus.frame_valid), 32'h1);
      chk("s2_selerr",  32'(bus.sel_err), 32'h1);

      // Reset on the 3rd edge of a stable run.
      show(4'b0001, 7'b0000010);
      step(2);
      rst_n = 1'b0;
      step(1);
      chk("mr_value",   32'(bus.value),   32'h0000);
      chk("mr_blank",   32'(bus.blank),   32'hF);
      chk("mr_negi",    32'({bus.neg, bus.invalid}), 32'h00);
      chk("mr_selerr",  32'(bus.sel_err), 32'h0);
      chk("mr_fv",      32'(bus.frame_valid), 32'h0);
      rst_n = 1'b1;
      step(3);
      chk("mr_nocap",   32'(bus.value), 32'h0000);
      step(1);
      chk("mr_value2",  32'(bus.value), 32'h0006);
      chk("mr_blank2",  32'(bus.blank), 32'hE);

      // Long hold: no re-capture, no frame pulse.
      for (int i = 0; i < 16; i++) begin
         step(1);
         chk("hold_fv", 32'(bus.frame_valid), 32'h0);
      end
      chk("hold_value", 32'(bus.value), 32'h0006);
      show(4'b0010, 7'b0011000);
      step(4);
      chk("hold_d1",    32'(bus.value), 32'h0096);
      chk("hold_fv2",   32'(bus.frame_valid), 32'h0);

      // Single-digit instance: each valid capture yields a frame pulse.
      bus1.segs = 7'b1111001;
      step(4);
      chk("n1_value2",  32'(bus1.value), 32'h1);
      chk("n1_fv2_pre", 32'(bus1.frame_valid), 32'h0);
      step(1);
      chk("n1_fv2",     32'(bus1.frame_valid), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digit positions, 1..8.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured, 2..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 segs  input  7  active-low segment lines, bit order {g,f,e,d,c,b,a}, bit 0 = segment a.
REQ-006 digit_sel  input  NUM_DIGITS  active-high digit enable; bit i = digit i driven.
REQ-007 value  output  4*NUM_DIGITS  decoded hex nibble per digit; digit i in bits [4i+3:4i].
REQ-008 neg  output  NUM_DIGITS  digit i last captured as minus sign.
REQ-009 blank  output  NUM_DIGITS  digit i last captured as all segments off.
REQ-010 invalid  output  NUM_DIGITS  digit i last captured as an unrecognised pattern.
REQ-011 frame_valid  output  1  one-cycle pulse: every digit captured at least once since the previous pulse or reset.
REQ-012 sel_err  output  1  sticky flag: digit_sel was stable but not one-hot for STABLE_CYCLES samples.

Function
REQ-013 Sample = {digit_sel, segs}, registered on every rising edge.
REQ-014 Stability counter: cleared to 0 when the current sample differs from the previous registered sample; otherwise incremented, saturating at STABLE_CYCLES.
REQ-015 Capture fires exactly once per stable run, on the edge where a sample has been identical for STABLE_CYCLES consecutive edges (counter transitions STABLE_CYCLES-1 -> STABLE_CYCLES); captured data is visible on outputs the following cycle.
REQ-016 A run held longer than STABLE_CYCLES does not re-capture; a changed sample starts a new run.
REQ-017 Capture with digit_sel one-hot (bit i): write slot i only; all other slots hold.
REQ-018 Capture with digit_sel zero or multi-hot: no slot written, seen mask unchanged; sel_err set to 1 and held until reset.
REQ-019 Decode (segs -> value): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F; slot flags neg=blank=invalid=0.
REQ-020 0111111 -> neg=1, value=0; 1111111 -> blank=1, value=0; any other pattern -> invalid=1, value=0. Exactly one of {hex, neg, blank, invalid} per slot.
REQ-021 Seen mask (NUM_DIGITS bits): bit i set on capture into slot i.
REQ-022 When the seen mask becomes all ones, frame_valid=1 on the next cycle only, and the seen mask clears in the same cycle frame_valid asserts; a capture coinciding with that clear sets its bit in the new mask.
REQ-023 Slot contents persist across frames; frame_valid does not clear value/flag outputs.
REQ-024 NUM_DIGITS=1: every valid capture produces frame_valid one cycle later.

Reset
REQ-025 rst_n=0 at a rising edge: value=0, neg=0, blank=all ones, invalid=0, frame_valid=0, sel_err=0, seen mask=0, stability counter=0, sample register=0, effective the following cycle.
REQ-026 Reset asserted mid-run aborts the run; after release, a pattern requires a full STABLE_CYCLES run to capture, regardless of stability before reset.
REQ-027 Reset has priority over capture and frame_valid generation on the same edge.

Verification
REQ-028 Defaults; digit_sel=0001, segs=0100100 held 4 edges -> value[3:0]=2 the cycle after the 4th edge; other slots blank=1.
REQ-029 Digit_sel=0010, segs=0011001 for 3 edges, then segs=0110000 for 4 edges -> no capture of 4; value[7:4]=3 after the 7th edge.
REQ-030 Scan 0001:0111111, 0010:1111111, 0100:1010101, 1000:0001110, each held 5 edges -> neg[0]=1, blank[1]=1, invalid[2]=1, value[15:12]=F, frame_valid high exactly one cycle after the last capture is visible.
REQ-031 Digit_sel=0110 held 4 edges -> sel_err=1 persists, no slot or seen-mask change; later valid scans still produce frame_valid.
REQ-032 Reset asserted at 3rd edge of a stable run and released -> all outputs at reset values; capture requires 4 further stable edges.
REQ-033 Same pattern held 20 edges -> single capture; frame_valid not repeated without other digits.
